// File: rtl/sd4_pkg.sv
// ============================================================================
// Module      : sd4_pkg
// Description : Shared widths and helpers for the SD4 block-floating-point
//               MAC align/accumulate stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd4_pkg;

    localparam int PP_W      = 5;   // signed partial-product width
    localparam int EXP_W     = 5;   // unsigned exponent width
    localparam int ALN_W     = 16;  // aligned partial-product width
    localparam int SUM_W     = 20;  // accumulated sum width
    localparam int LANES     = 9;   // partial products per bundle
    localparam int MAX_SHIFT = 15;  // alignment shift clamp

    // Fraction bits appended below the pp so right shifts keep precision.
    localparam int FRAC_W    = ALN_W - PP_W;

    function automatic logic [EXP_W-1:0] max_exp(
        input logic [EXP_W-1:0] a,
        input logic [EXP_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage : sd4_pkg

`default_nettype wire

// File: rtl/sd4_align_lane.sv
// ============================================================================
// Module      : sd4_align_lane
// Description : Combinational alignment of one partial product to the
//               bundle's maximum exponent (arithmetic right shift, clamped).
// Ports       : i_pp      - signed partial product
//               i_exp     - exponent of this lane
//               i_exp_max - maximum exponent of the bundle
//               o_aligned - pp placed in [15:11], shifted right by the
//                           exponent difference (clamped to MAX_SHIFT)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd4_align_lane
    import sd4_pkg::*;
(
    input  logic [PP_W-1:0]  i_pp,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [EXP_W-1:0] i_exp_max,
    output logic [ALN_W-1:0] o_aligned
);

    logic [EXP_W-1:0] w_diff;
    logic [3:0]       w_shift;

    // i_exp_max >= i_exp by construction, so the difference never wraps.
    assign w_diff  = i_exp_max - i_exp;
    assign w_shift = (w_diff > EXP_W'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : w_diff[3:0];

    // Truncating the shifted-out bits rounds toward minus infinity.
    assign o_aligned = $signed({i_pp, {FRAC_W{1'b0}}}) >>> w_shift;

endmodule : sd4_align_lane

`default_nettype wire

// File: rtl/sd4_align_accumulate.sv
// ============================================================================
// Module      : sd4_align_accumulate
// Description : Two-stage pipeline: stage 1 finds the maximum exponent and
//               aligns the nine partial products; stage 2 sums them.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               in_valid       - input bundle valid
//               signed_pp_all  - {pp_0..pp_8}, 5-bit two's complement each
//               exp_all        - {exp_0..exp_8}, 5-bit unsigned each
//               out_valid      - outputs carry an accepted bundle
//               exp_max        - maximum exponent
//               aligned_pp_all - {aligned_0..aligned_8}, 16 bits each
//               signed_sum     - 20-bit sum of the aligned values
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd4_align_accumulate
    import sd4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [LANES*PP_W-1:0]  signed_pp_all,
    input  logic [LANES*EXP_W-1:0] exp_all,
    output logic                   out_valid,
    output logic [EXP_W-1:0]       exp_max,
    output logic [LANES*ALN_W-1:0] aligned_pp_all,
    output logic [SUM_W-1:0]       signed_sum
);

    logic [PP_W-1:0]  w_pp      [LANES];
    logic [EXP_W-1:0] w_exp     [LANES];
    logic [ALN_W-1:0] w_aligned [LANES];

    // Max-exponent tree 9 -> 5 -> 3 -> 2 -> 1
    logic [EXP_W-1:0] w_m1 [5];
    logic [EXP_W-1:0] w_m2 [3];
    logic [EXP_W-1:0] w_m3 [2];
    logic [EXP_W-1:0] w_exp_max;

    // Adder tree 9 -> 5 -> 3 -> 2 -> 1
    logic [SUM_W-1:0] w_a0 [LANES];
    logic [SUM_W-1:0] w_a1 [5];
    logic [SUM_W-1:0] w_a2 [3];
    logic [SUM_W-1:0] w_a3 [2];
    logic [SUM_W-1:0] w_sum;

    // Pipeline registers
    logic             r_s1_valid;
    logic [EXP_W-1:0] r_s1_exp_max;
    logic [ALN_W-1:0] r_s1_aligned [LANES];
    logic             r_s2_valid;
    logic [EXP_W-1:0] r_s2_exp_max;
    logic [ALN_W-1:0] r_s2_aligned [LANES];
    logic [SUM_W-1:0] r_s2_sum;

    // Lane 0 occupies the most significant field of every packed bus.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_pp[gi]  = signed_pp_all[(LANES-1-gi)*PP_W +: PP_W];
            assign w_exp[gi] = exp_all[(LANES-1-gi)*EXP_W +: EXP_W];

            sd4_align_lane u_lane (
                .i_pp      (w_pp[gi]),
                .i_exp     (w_exp[gi]),
                .i_exp_max (w_exp_max),
                .o_aligned (w_aligned[gi])
            );

            assign aligned_pp_all[(LANES-1-gi)*ALN_W +: ALN_W] = r_s2_aligned[gi];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_m1[i] = max_exp(w_exp[2*i], w_exp[2*i+1]);
        end
        w_m1[4]   = w_exp[8];
        w_m2[0]   = max_exp(w_m1[0], w_m1[1]);
        w_m2[1]   = max_exp(w_m1[2], w_m1[3]);
        w_m2[2]   = w_m1[4];
        w_m3[0]   = max_exp(w_m2[0], w_m2[1]);
        w_m3[1]   = w_m2[2];
        w_exp_max = max_exp(w_m3[0], w_m3[1]);
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_a0[i] = {{(SUM_W-ALN_W){r_s1_aligned[i][ALN_W-1]}}, r_s1_aligned[i]};
        end
        for (int i = 0; i < 4; i++) begin
            w_a1[i] = w_a0[2*i] + w_a0[2*i+1];
        end
        w_a1[4] = w_a0[8];
        w_a2[0] = w_a1[0] + w_a1[1];
        w_a2[1] = w_a1[2] + w_a1[3];
        w_a2[2] = w_a1[4];
        w_a3[0] = w_a2[0] + w_a2[1];
        w_a3[1] = w_a2[2];
        w_sum   = w_a3[0] + w_a3[1];
    end

    // Stage 1: exponent max and alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_exp_max <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_aligned[i] <= '0;
            end
        end else begin
            r_s1_valid   <= in_valid;
            r_s1_exp_max <= w_exp_max;
            for (int i = 0; i < LANES; i++) begin
                r_s1_aligned[i] <= w_aligned[i];
            end
        end
    end

    // Stage 2: sum, with exponent and aligned values carried alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_exp_max <= '0;
            r_s2_sum     <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s2_aligned[i] <= '0;
            end
        end else begin
            r_s2_valid   <= r_s1_valid;
            r_s2_exp_max <= r_s1_exp_max;
            r_s2_sum     <= w_sum;
            for (int i = 0; i < LANES; i++) begin
                r_s2_aligned[i] <= r_s1_aligned[i];
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign exp_max    = r_s2_exp_max;
    assign signed_sum = r_s2_sum;

endmodule : sd4_align_accumulate

`default_nettype wire

// File: tb/tb_sd4_align_accumulate.sv
// ============================================================================
// Module      : tb_sd4_align_accumulate
// Description : Self-checking bench for sd4_align_accumulate: directed
//               vectors plus randomized bundles against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd4_align_accumulate;

    typedef struct {
        bit           v;
        bit [4:0]     em;
        bit [143:0]   al;
        bit [19:0]    sum;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [44:0]   signed_pp_all;
    logic [44:0]   exp_all;
    logic          out_valid;
    logic [4:0]    exp_max;
    logic [143:0]  aligned_pp_all;
    logic [19:0]   signed_sum;

    int   n_checks;
    int   n_errors;
    exp_t q[$];

    sd4_align_accumulate dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .signed_pp_all  (signed_pp_all),
        .exp_all        (exp_all),
        .out_valid      (out_valid),
        .exp_max        (exp_max),
        .aligned_pp_all (aligned_pp_all),
        .signed_sum     (signed_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: value = floor(pp * 2^11 / 2^d), d = min(max_exp - exp, 15).
    function automatic exp_t model(input bit v, input logic [44:0] pp, input logic [44:0] ex);
        exp_t r;
        int   mx;
        int   s;
        mx = 0;
        s  = 0;
        r.v  = v;
        r.al = '0;
        for (int i = 0; i < 9; i++) begin
            if (int'(ex[44-5*i -: 5]) > mx) mx = int'(ex[44-5*i -: 5]);
        end
        for (int i = 0; i < 9; i++) begin
            logic signed [4:0] p5;
            int p, d, val, dv, qt;
            p5  = pp[44-5*i -: 5];
            p   = int'(p5);
            d   = mx - int'(ex[44-5*i -: 5]);
            if (d > 15) d = 15;
            val = p * 2048;
            dv  = 1 << d;
            qt  = val / dv;
            if (val < 0 && qt * dv != val) qt = qt - 1;
            r.al[143-16*i -: 16] = qt[15:0];
            s = s + qt;
        end
        r.em  = mx[4:0];
        r.sum = s[19:0];
        return r;
    endfunction

    function automatic exp_t zero_exp();
        exp_t r;
        r.v = 1'b0; r.em = '0; r.al = '0; r.sum = '0;
        return r;
    endfunction

    function automatic logic [44:0] pack(input int a[9]);
        logic [44:0] r;
        for (int i = 0; i < 9; i++) r[44-5*i -: 5] = a[i][4:0];
        return r;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".valid"}, 144'(out_valid), 144'(e.v));
        chk({tag, ".exp_max"}, 144'(exp_max), 144'(e.em));
        chk({tag, ".aligned"}, aligned_pp_all, e.al);
        chk({tag, ".sum"}, 144'(signed_sum), 144'(e.sum));
    endtask

    // Drive a bundle for one cycle and compare the outputs of the bundle
    // driven on the previous cycle (two edges of latency).
    task automatic apply(input string tag, input bit v, input logic [44:0] pp, input logic [44:0] ex);
        @(negedge clk);
        in_valid      = v;
        signed_pp_all = pp;
        exp_all       = ex;
        @(posedge clk);
        q.push_back(model(v, pp, ex));
        #1;
        if (q.size() >= 2) begin
            check_outputs(tag, q[0]);
            void'(q.pop_front());
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".valid"}, 144'(out_valid), 144'(0));
        chk({tag, ".exp_max"}, 144'(exp_max), 144'(0));
        chk({tag, ".aligned"}, aligned_pp_all, 144'(0));
        chk({tag, ".sum"}, 144'(signed_sum), 144'(0));
    endtask

    task automatic drive_directed(input string tag, input int pa[9], input int ea[9]);
        apply(tag, 1'b1, pack(pa), pack(ea));
    endtask

    initial begin
        int pa[9];
        int ea[9];
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        signed_pp_all = '0;
        exp_all       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(zero_exp());

        // All lanes equal: pp=+1, exp=10
        for (int i = 0; i < 9; i++) begin pa[i] = 1; ea[i] = 10; end
        drive_directed("equal_in", pa, ea);
        apply("equal", 1'b0, '0, '0);
        // Hard-coded expectation for the first directed case.
        chk("equal.const_sum", 144'(signed_sum), 144'(20'h04800));
        chk("equal.const_al0", 144'(aligned_pp_all[143:128]), 144'(16'h0800));
        chk("equal.const_em", 144'(exp_max), 144'(5'd10));

        // Mixed shift
        for (int i = 0; i < 9; i++) begin pa[i] = 0; ea[i] = 0; end
        pa[0] = 15; ea[0] = 5; pa[1] = 8; ea[1] = 7;
        drive_directed("mixed_in", pa, ea);
        apply("mixed", 1'b0, '0, '0);
        chk("mixed.const_sum", 144'(signed_sum), 144'(20'h05E00));
        chk("mixed.const_al0", 144'(aligned_pp_all[143:128]), 144'(16'h1E00));
        chk("mixed.const_al1", 144'(aligned_pp_all[127:112]), 144'(16'h4000));

        // Clamp and sign fill
        for (int i = 0; i < 9; i++) begin pa[i] = 0; ea[i] = 0; end
        pa[0] = -1; ea[0] = 0; pa[1] = 1; ea[1] = 31;
        drive_directed("clamp_in", pa, ea);
        apply("clamp", 1'b0, '0, '0);
        chk("clamp.const_sum", 144'(signed_sum), 144'(20'h007FF));
        chk("clamp.const_al0", 144'(aligned_pp_all[143:128]), 144'(16'hFFFF));

        // Extremes
        for (int i = 0; i < 9; i++) begin pa[i] = 15; ea[i] = 20; end
        drive_directed("pos_in", pa, ea);
        apply("pos", 1'b0, '0, '0);
        chk("pos.const_sum", 144'(signed_sum), 144'(20'h43800));
        for (int i = 0; i < 9; i++) begin pa[i] = -16; ea[i] = 3; end
        drive_directed("neg_in", pa, ea);
        apply("neg", 1'b0, '0, '0);
        chk("neg.const_sum", 144'(signed_sum), 144'(20'hB8000));

        // Streaming: three back-to-back bundles, a one-cycle gap, one more
        for (int k = 0; k < 3; k++) begin
            apply("stream", 1'b1, 45'({$urandom, $urandom}), 45'({$urandom, $urandom}));
        end
        apply("stream_gap", 1'b0, 45'({$urandom, $urandom}), 45'({$urandom, $urandom}));
        apply("stream_last", 1'b1, 45'({$urandom, $urandom}), 45'({$urandom, $urandom}));
        apply("stream_drain", 1'b0, '0, '0);

        // Randomized: exponents near a common base so small shifts dominate
        for (int k = 0; k < 300; k++) begin
            logic [44:0] pp;
            logic [44:0] ex;
            int base;
            base = int'($urandom_range(0, 31));
            pp   = 45'({$urandom, $urandom});
            for (int i = 0; i < 9; i++) begin
                int e5;
                if ($urandom_range(0, 3) == 0) e5 = int'($urandom_range(0, 31));
                else begin
                    e5 = base - int'($urandom_range(0, 16));
                    if (e5 < 0) e5 = 0;
                end
                ex[44-5*i -: 5] = e5[4:0];
            end
            apply("rand", 1'($urandom_range(0, 1)), pp, ex);
        end

        // Reset mid-stream with two bundles in flight
        apply("pre_rst_a", 1'b1, 45'({$urandom, $urandom}), 45'({$urandom, $urandom}));
        apply("pre_rst_b", 1'b1, 45'({$urandom, $urandom}), 45'({$urandom, $urandom}));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        in_valid      = 1'b0;
        signed_pp_all = '0;
        exp_all       = '0;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        q.push_back(zero_exp());
        for (int k = 0; k < 3; k++) apply("post_rst", 1'b0, '0, '0);
        e = model(1'b1, 45'h0_1234_5678, 45'h0_0842_1084);
        apply("post_rst_new", 1'b1, 45'h0_1234_5678, 45'h0_0842_1084);
        apply("post_rst_out", 1'b0, '0, '0);
        chk("post_rst.valid_direct", 144'(out_valid), 144'(e.v));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_sd4_align_accumulate

`default_nettype wire
